// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one single-port, byte-addressed, big-endian memory
//               between an instruction-fetch requester (IF) and a data
//               requester (DM). Each access takes three cycles: grant in IDLE,
//               one memory cycle in ACCESS, then a one-cycle ready pulse in
//               DONE. Simultaneous requests alternate priority. Every access
//               is range-checked at grant time, and a faulting access never
//               reaches the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int MEM_BYTES = 2048,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    // instruction-fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_instr,
    output logic              if_err,
    // data requester
    input  logic              dm_req,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [63:0]       dm_wdata,
    output logic              dm_ready,
    output logic [63:0]       dm_rdata,
    output logic              dm_err,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] endereco,
    output logic [63:0]       write_data,
    input  logic [63:0]       read_data
);

    localparam logic          c_GRANT_IF    = 1'b0;
    localparam logic          c_GRANT_DM    = 1'b1;
    // The range check uses one extra bit so that addresses near the top of
    // the address space cannot wrap around and pass.
    localparam logic [ADDR_W:0] c_MEM_LIMIT   = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] c_FETCH_BYTES = (ADDR_W+1)'(4);
    localparam logic [ADDR_W:0] c_DATA_BYTES  = (ADDR_W+1)'(8);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [63:0]         r_wdata;
    logic                r_fault;

    logic                w_req_any;
    logic                w_grant_dm;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [ADDR_W:0]     w_need;
    logic [ADDR_W:0]     w_end;
    logic                w_fault;
    logic                w_mem_active;

    // Grant selection: a lone requester wins; on a tie the side that was not
    // served last wins.
    always_comb begin
        w_req_any = if_req | dm_req;
        if (if_req && dm_req) begin
            w_grant_dm = (r_last_grant == c_GRANT_IF);
        end else begin
            w_grant_dm = dm_req;
        end
        w_sel_addr = w_grant_dm ? dm_addr : if_addr;
        w_need     = w_grant_dm ? c_DATA_BYTES : c_FETCH_BYTES;
        w_end      = {1'b0, w_sel_addr} + w_need;
        w_fault    = (w_end > c_MEM_LIMIT);
    end

    // Memory is driven only during a non-faulting ACCESS cycle. The store
    // strobe is also gated by reset so a reset edge can never commit a store.
    always_comb begin
        w_mem_active = (r_state == S_ACCESS) && !r_fault;
        mem_read     = w_mem_active && !r_write;
        mem_write    = w_mem_active && r_write && !reset;
        endereco     = w_mem_active ? r_addr  : '0;
        write_data   = w_mem_active ? r_wdata : '0;
    end

    // Arbitration FSM: latch the granted request, run one memory cycle,
    // then present a one-cycle ready/err pulse to the granted side.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_GRANT_IF;
            r_grant      <= c_GRANT_IF;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_fault      <= 1'b0;
            if_ready     <= 1'b0;
            if_err       <= 1'b0;
            if_instr     <= '0;
            dm_ready     <= 1'b0;
            dm_err       <= 1'b0;
            dm_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_grant      <= w_grant_dm;
                        r_last_grant <= w_grant_dm;
                        r_addr       <= w_sel_addr;
                        r_write      <= w_grant_dm && dm_write;
                        r_wdata      <= w_grant_dm ? dm_wdata : '0;
                        r_fault      <= w_fault;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_grant == c_GRANT_DM) begin
                        dm_rdata <= (r_fault || r_write) ? '0 : read_data;
                        dm_ready <= 1'b1;
                        dm_err   <= r_fault;
                    end else begin
                        if_instr <= r_fault ? '0 : read_data[63:32];
                        if_ready <= 1'b1;
                        if_err   <= r_fault;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if_ready <= 1'b0;
                    if_err   <= 1'b0;
                    dm_ready <= 1'b0;
                    dm_err   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter. A byte-array memory
//               sits behind the arbiter. A transaction-level reference model
//               (its own byte image plus the address-range rules) predicts
//               every result, fault, latency and grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int c_MEM_BYTES = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        if_err;
    logic        dm_req = 1'b0;
    logic        dm_write = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_ready;
    logic [63:0] dm_rdata;
    logic        dm_err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] endereco;
    logic [63:0] write_data;
    logic [63:0] read_data;

    memory_arbiter #(.MEM_BYTES(c_MEM_BYTES), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_instr(if_instr), .if_err(if_err),
        .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .dm_err(dm_err),
        .mem_read(mem_read), .mem_write(mem_write), .endereco(endereco),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // Physical memory behind the arbiter, and the model's own byte image.
    logic [7:0] mem     [0:c_MEM_BYTES-1];
    logic [7:0] ref_mem [0:c_MEM_BYTES-1];
    logic       mem_sync = 1'b0;
    int         wr_pulses = 0;
    int         checks = 0;
    int         failures = 0;

    // Big-endian combinational read port; bytes past the end read as zero.
    always_comb begin
        read_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (endereco < 64'(c_MEM_BYTES) && endereco + 64'(i) < 64'(c_MEM_BYTES))
                read_data[63-8*i -: 8] = mem[int'(endereco) + i];
        end
    end

    // Memory write port, plus one-time preload from the model image.
    always @(posedge clk) begin
        if (mem_sync) begin
            for (int i = 0; i < c_MEM_BYTES; i++) mem[i] <= ref_mem[i];
        end else if (mem_write) begin
            wr_pulses <= wr_pulses + 1;
            for (int i = 0; i < 8; i++) begin
                if (endereco < 64'(c_MEM_BYTES) && endereco + 64'(i) < 64'(c_MEM_BYTES))
                    mem[int'(endereco) + i] <= write_data[63-8*i -: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: range rules and big-endian byte image.
    function automatic bit ref_fetch_ok(input logic [63:0] a);
        return a <= 64'(c_MEM_BYTES - 4);
    endfunction

    function automatic bit ref_data_ok(input logic [63:0] a);
        return a <= 64'(c_MEM_BYTES - 8);
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], ref_mem[int'(a) + i]};
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = d[63-8*i -: 8];
    endtask

    function automatic logic [63:0] phys_load(input int a);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[55:0], mem[a + i]};
        return v;
    endfunction

    function automatic logic [63:0] rand_addr(input bit side);
        int sel;
        int lim;
        sel = int'($urandom_range(0, 9));
        lim = side ? c_MEM_BYTES - 8 : c_MEM_BYTES - 4;
        if (sel <= 6)      return 64'($urandom_range(0, lim));
        else if (sel == 7) return 64'($urandom_range(c_MEM_BYTES - 16, c_MEM_BYTES - 1));
        else if (sel == 8) return {32'hFFFF_FFFF, 32'($urandom)};
        else               return 64'(lim + int'($urandom_range(0, 1)));
    endfunction

    // One isolated transaction from IDLE; side 0 = IF, 1 = DM.
    task automatic txn(input bit side, input bit wr, input logic [63:0] addr,
                       input logic [63:0] wd);
        bit          ok;
        bit          got;
        int          waited;
        int          pulses0;
        logic [63:0] exp_rd;
        ok     = side ? ref_data_ok(addr) : ref_fetch_ok(addr);
        exp_rd = '0;
        if (ok && !wr) exp_rd = ref_load(addr, side ? 8 : 4);
        pulses0 = wr_pulses;
        if (side) begin
            dm_req = 1'b1; dm_write = wr; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        check("acc_mem_read", 64'(mem_read), 64'(ok && !wr));
        check("acc_mem_write", 64'(mem_write), 64'(ok && wr));
        check("acc_endereco", endereco, ok ? addr : 64'd0);
        if (wr) check("acc_write_data", write_data, ok ? wd : 64'd0);
        waited = 1;
        got    = 1'b0;
        while (!got && waited < 8) begin
            tick();
            waited++;
            got = side ? dm_ready : if_ready;
        end
        check("ready_latency", 64'(waited), 64'd2);
        if (side) begin
            check("dm_err", 64'(dm_err), 64'(!ok));
            check("dm_rdata", dm_rdata, exp_rd);
            check("if_ready_idle", 64'(if_ready), 64'd0);
        end else begin
            check("if_err", 64'(if_err), 64'(!ok));
            check("if_instr", 64'(if_instr), exp_rd);
            check("dm_ready_idle", 64'(dm_ready), 64'd0);
        end
        check("done_mem_quiet", {62'd0, mem_read, mem_write}, 64'd0);
        check("store_pulses", 64'(wr_pulses - pulses0), 64'(ok && wr));
        if (ok && wr) ref_store(addr, wd);
        if_req = 1'b0; dm_req = 1'b0; dm_write = 1'b0;
        tick();
        check("ready_clears", {62'd0, if_ready, dm_ready}, 64'd0);
    endtask

    initial begin
        bit          exp_side;
        bit          got;
        bit          side;
        bit          wr;
        int          n;
        int          pulses0;
        logic [63:0] a_if;
        logic [63:0] a_dm;
        logic [63:0] wd;
        logic [63:0] last_st;

        // Model image: random fill plus the directed patterns.
        for (int i = 0; i < c_MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
        ref_mem[1023] = 8'h00; ref_mem[1024] = 8'h00;
        ref_mem[1025] = 8'h20; ref_mem[1026] = 8'h83;
        ref_store(64'd0, 64'h0000_0000_0000_0008);
        mem_sync = 1'b1;
        tick();
        mem_sync = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ready", {62'd0, if_ready, dm_ready}, 64'd0);
        check("rst_err", {62'd0, if_err, dm_err}, 64'd0);
        check("rst_if_instr", 64'(if_instr), 64'd0);
        check("rst_dm_rdata", dm_rdata, 64'd0);
        check("rst_mem_ctl", {62'd0, mem_read, mem_write}, 64'd0);
        check("rst_endereco", endereco, 64'd0);
        check("rst_write_data", write_data, 64'd0);
        reset = 1'b0;
        tick();

        // Directed single transactions
        txn(1'b0, 1'b0, 64'd1023, 64'd0);
        check("fetch_1023_value", 64'(if_instr), 64'h0000_2083);
        txn(1'b1, 1'b0, 64'd0, 64'd0);
        check("load_0_value", dm_rdata, 64'd8);
        txn(1'b1, 1'b1, 64'd24, 64'h0000_0000_0000_000E);
        txn(1'b1, 1'b0, 64'd24, 64'd0);
        check("load_24_value", dm_rdata, 64'h0000_0000_0000_000E);
        txn(1'b1, 1'b0, 64'd2041, 64'd0);
        txn(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        txn(1'b0, 1'b0, 64'd2044, 64'd0);

        // Both requests present out of reset: DM first, IF three cycles later
        reset = 1'b1;
        if_req = 1'b1; if_addr = 64'd1023;
        dm_req = 1'b1; dm_write = 1'b0; dm_addr = 64'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("tie_c2_dm_ready", 64'(dm_ready), 64'd1);
        check("tie_c2_if_ready", 64'(if_ready), 64'd0);
        check("tie_c2_dm_rdata", dm_rdata, ref_load(64'd0, 8));
        dm_req = 1'b0;
        tick();
        tick();
        check("tie_c4_ready", {62'd0, if_ready, dm_ready}, 64'd0);
        tick();
        check("tie_c5_if_ready", 64'(if_ready), 64'd1);
        check("tie_c5_if_instr", 64'(if_instr), ref_load(64'd1023, 4));
        if_req = 1'b0;
        tick();

        // Continuous contention: grants alternate, starting with DM since IF won last
        a_if = 64'($urandom_range(0, c_MEM_BYTES - 4));
        a_dm = 64'($urandom_range(0, c_MEM_BYTES - 8));
        if_req = 1'b1; if_addr = a_if;
        dm_req = 1'b1; dm_write = 1'b0; dm_addr = a_dm;
        exp_side = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 6) begin
                tick();
                n++;
                got = if_ready | dm_ready;
            end
            check("alt_ready_seen", 64'(got), 64'd1);
            check("alt_grant_side", {62'd0, dm_ready, if_ready}, exp_side ? 64'd2 : 64'd1);
            if (exp_side) check("alt_dm_rdata", dm_rdata, ref_load(a_dm, 8));
            else          check("alt_if_instr", 64'(if_instr), ref_load(a_if, 4));
            exp_side = !exp_side;
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();

        // Reset during the ACCESS cycle of a store discards it
        wd = {$urandom, $urandom};
        pulses0 = wr_pulses;
        dm_req = 1'b1; dm_write = 1'b1; dm_addr = 64'd16; dm_wdata = wd;
        tick();
        reset = 1'b1;
        #1;
        check("rstmid_mem_write", 64'(mem_write), 64'd0);
        tick();
        check("rstmid_dm_ready", 64'(dm_ready), 64'd0);
        check("rstmid_pulses", 64'(wr_pulses - pulses0), 64'd0);
        check("rstmid_mem16", phys_load(16), ref_load(64'd16, 8));
        reset = 1'b0; dm_req = 1'b0; dm_write = 1'b0;
        tick();
        check("rstmid_idle_ready", {62'd0, if_ready, dm_ready}, 64'd0);
        check("rstmid_idle_mem", {62'd0, mem_read, mem_write}, 64'd0);

        // Randomized isolated transactions against the model
        last_st = 64'd0;
        for (int t = 0; t < 40; t++) begin
            side = 1'($urandom_range(0, 1));
            wr   = side ? 1'($urandom_range(0, 1)) : 1'b0;
            a_dm = rand_addr(side);
            if (side && !wr && $urandom_range(0, 2) == 0) a_dm = last_st;
            wd = {$urandom, $urandom};
            if (side && wr && ref_data_ok(a_dm)) last_st = a_dm;
            txn(side, wr, a_dm, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
